// File: rtl/ekf_tb_pkg.sv
// Shared encodings for the TB read-out sequencer: op codes, TB_doutb_sel
// modes, FSM states and the fixed cache step count.
package ekf_tb_pkg;

  // Command op codes
  localparam logic [2:0] OP_B_POS       = 3'b000;
  localparam logic [2:0] OP_B_NEG       = 3'b001;
  localparam logic [2:0] OP_B_NEW       = 3'b010;
  localparam logic [2:0] OP_C_TRANSFER  = 3'b011;
  localparam logic [2:0] OP_C_TRANSPOSE = 3'b100;
  localparam logic [2:0] OP_C_INV       = 3'b101;

  // TB_doutb_sel encodings seen by TB_doutb_map
  localparam logic [2:0] DIR_IDLE           = 3'b000;
  localparam logic [2:0] DIR_POS            = 3'b001;
  localparam logic [2:0] DIR_NEG            = 3'b010;
  localparam logic [2:0] DIR_NEW            = 3'b011;
  localparam logic [2:0] B_CACHE_TRANSFER   = 3'b101;
  localparam logic [2:0] B_CACHE_TRANSPOSE  = 3'b110;
  localparam logic [2:0] B_CACHE_INV        = 3'b111;

  // Transpose and inverse walk a fixed 8-row cache block
  localparam int CACHE_SEQ_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  function automatic logic [2:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_B_POS:       op_to_sel = DIR_POS;
      OP_B_NEG:       op_to_sel = DIR_NEG;
      OP_B_NEW:       op_to_sel = DIR_NEW;
      OP_C_TRANSFER:  op_to_sel = B_CACHE_TRANSFER;
      OP_C_TRANSPOSE: op_to_sel = B_CACHE_TRANSPOSE;
      OP_C_INV:       op_to_sel = B_CACHE_INV;
      default:        op_to_sel = DIR_IDLE;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= OP_C_INV);
  endfunction

  function automatic logic op_fixed_len(input logic [2:0] op);
    op_fixed_len = (op == OP_C_TRANSPOSE) || (op == OP_C_INV);
  endfunction

endpackage

// File: rtl/tb_seq_dly.sv
// DEPTH-stage register pipe aligning step side-band with BRAM read latency.
// Synchronous clear empties every stage at once.
module tb_seq_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] pipe;

  // Shift one stage per cycle; clear wipes in-flight steps
  always_ff @(posedge clk) begin
    if (clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/tb_dout_seq_ctrl.sv
// TB read-path sequencer: issues TB port-B reads for one command at a time and
// drives TB_doutb_map side-band aligned to the BRAM read latency.
// Optional: define TB_DOUT_SEQ_PERF_EN for busy-cycle / command counters.
module tb_dout_seq_ctrl
  import ekf_tb_pkg::*;
#(
  parameter int TB_AW      = 10,
  parameter int SEQ_CNT_DW = 5,
  parameter int LEN_W      = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [TB_AW-1:0]      cmd_base,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_l_k_0,
  output logic                  TB_enb,
  output logic [TB_AW-1:0]      TB_addrb,
  output logic [2:0]            TB_doutb_sel,
  output logic                  l_k_0,
  output logic [SEQ_CNT_DW-1:0] seq_cnt_dout_sel,
  output logic                  map_out_valid,
  output logic                  done,
  output logic                  cmd_err
`ifdef TB_DOUT_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_busy_cyc,
  output logic [15:0]           perf_cmd_cnt
`endif
);

  // Step counter must hold both len and the fixed cache count of 8
  localparam int CW = (LEN_W > 3) ? LEN_W : 3;
  localparam int DW = 1 + 3 + 1 + SEQ_CNT_DW;

  seq_state_t       state, nxt;
  logic [CW-1:0]    k_q, last_q;
  logic [TB_AW-1:0] base_q;
  logic [2:0]       sel_q;
  logic             lk_q;
  logic [1:0]       drain_q;
  logic             err_q;
  logic             mov_q;
  logic             hs, legal, issue;
  logic [DW-1:0]    dly_d, dly_q;

  assign hs    = cmd_valid & cmd_ready;
  assign legal = op_legal(cmd_op);
  assign issue = (state == ST_ISSUE);

  // State register
  always_ff @(posedge clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= nxt;
  end

  // Next-state: DRAIN holds RD_LAT+1 cycles so DONE follows the last valid
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (hs && legal) nxt = ST_ISSUE;
      ST_ISSUE: if (k_q == last_q) nxt = ST_DRAIN;
      ST_DRAIN: if (drain_q == 2'(RD_LAT)) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Command capture, step/drain counters and illegal-op flag
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      base_q  <= '0;
      sel_q   <= DIR_IDLE;
      lk_q    <= 1'b0;
      last_q  <= '0;
      k_q     <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs && legal) begin
        base_q <= cmd_base;
        sel_q  <= op_to_sel(cmd_op);
        lk_q   <= cmd_l_k_0;
        last_q <= op_fixed_len(cmd_op) ? CW'(CACHE_SEQ_LEN - 1) : CW'(cmd_len);
        k_q    <= '0;
      end else if (issue) begin
        k_q <= k_q + 1'b1;
      end
      drain_q <= (state == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
      err_q   <= hs & ~legal;
    end
  end

  // Step side-band enters the delay line only on issue cycles, so idle
  // stages carry all-zero (sel = DIR_IDLE).
  assign dly_d = issue ? {1'b1, sel_q, lk_q, SEQ_CNT_DW'(k_q)} : '0;

  tb_seq_dly #(.W(DW), .DEPTH(RD_LAT)) u_dly (
    .clk (clk),
    .clr (sys_rst),
    .d   (dly_d),
    .q   (dly_q)
  );

  // Map output registers load one cycle after the side-band is presented
  always_ff @(posedge clk) begin
    if (sys_rst) mov_q <= 1'b0;
    else         mov_q <= dly_q[DW-1];
  end

  // Outputs
  always_comb begin
    cmd_ready        = (state == ST_IDLE);
    TB_enb           = issue;
    TB_addrb         = issue ? base_q + TB_AW'(k_q) : '0;
    TB_doutb_sel     = dly_q[DW-2 -: 3];
    l_k_0            = dly_q[SEQ_CNT_DW];
    seq_cnt_dout_sel = dly_q[SEQ_CNT_DW-1:0];
    map_out_valid    = mov_q;
    done             = (state == ST_DONE);
    cmd_err          = err_q;
  end

`ifdef TB_DOUT_SEQ_PERF_EN
  // Saturating busy-cycle and completed-command counters
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      perf_busy_cyc <= '0;
      perf_cmd_cnt  <= '0;
    end else begin
      if (state != ST_IDLE && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (state == ST_DONE && perf_cmd_cnt != '1)  perf_cmd_cnt  <= perf_cmd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tb_dout_seq_ctrl.sv
// Directed bench for tb_dout_seq_ctrl: RD_LAT=1 instance for most tests,
// RD_LAT=2 instance for the deeper-latency cache inverse.
module tb_tb_dout_seq_ctrl;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid, cmd_valid2;
  logic [2:0] cmd_op;
  logic [9:0] cmd_base;
  logic [7:0] cmd_len;
  logic       cmd_l_k_0;

  logic       rdy1, enb1, lk1, mov1, done1, err1;
  logic [9:0] addr1;
  logic [2:0] sel1;
  logic [4:0] seq1;
  logic       rdy2, enb2, lk2, mov2, done2, err2;
  logic [9:0] addr2;
  logic [2:0] sel2;
  logic [4:0] seq2;

  int errors = 0;
  int checks = 0;
  int nmov, ndone, hs_cyc, done_cyc;

  always #5 clk = ~clk;

  tb_dout_seq_ctrl #(.TB_AW(10), .SEQ_CNT_DW(5), .LEN_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_l_k_0(cmd_l_k_0),
    .TB_enb(enb1), .TB_addrb(addr1), .TB_doutb_sel(sel1), .l_k_0(lk1),
    .seq_cnt_dout_sel(seq1), .map_out_valid(mov1), .done(done1), .cmd_err(err1)
  );

  tb_dout_seq_ctrl #(.TB_AW(10), .SEQ_CNT_DW(5), .LEN_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid2), .cmd_ready(rdy2),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_l_k_0(cmd_l_k_0),
    .TB_enb(enb2), .TB_addrb(addr2), .TB_doutb_sel(sel2), .l_k_0(lk2),
    .seq_cnt_dout_sel(seq2), .map_out_valid(mov2), .done(done2), .cmd_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, " enb"}, enb1, 0);
    chk({tag, " addr"}, addr1, 0);
    chk({tag, " sel"}, sel1, 0);
    chk({tag, " lk"}, lk1, 0);
    chk({tag, " seq"}, seq1, 0);
    chk({tag, " mov"}, mov1, 0);
    chk({tag, " done"}, done1, 0);
    chk({tag, " err"}, err1, 0);
    chk({tag, " rdy"}, rdy1, 1);
  endtask

  initial begin
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = 3'b000; cmd_base = '0; cmd_len = '0; cmd_l_k_0 = 1'b0;
    cyc(); cyc();
    chk_idle1("reset");
    chk("reset rdy2", rdy2, 1);
    chk("reset enb2", enb2, 0);
    sys_rst = 1'b0;
    cyc();

    // 1: B_POS base 0x010 len 3, l_k_0=1; fields changed after handshake
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_base = 10'h010; cmd_len = 8'd3; cmd_l_k_0 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      cmd_valid = 1'b0;
      if (c == 2) begin cmd_base = 10'h3FF; cmd_op = 3'b101; cmd_len = 8'd9; cmd_l_k_0 = 1'b0; end
      chk($sformatf("t1 enb c%0d", c), enb1, (c >= 1 && c <= 4));
      chk($sformatf("t1 addr c%0d", c), addr1, (c >= 1 && c <= 4) ? 32'h010 + c - 1 : 0);
      chk($sformatf("t1 sel c%0d", c), sel1, (c >= 2 && c <= 5) ? 3'b001 : 3'b000);
      chk($sformatf("t1 lk c%0d", c), lk1, (c >= 2 && c <= 5));
      chk($sformatf("t1 seq c%0d", c), seq1, (c >= 2 && c <= 5) ? c - 2 : 0);
      chk($sformatf("t1 mov c%0d", c), mov1, (c >= 3 && c <= 6));
      chk($sformatf("t1 done c%0d", c), done1, (c == 7));
      chk($sformatf("t1 rdy c%0d", c), rdy1, (c == 8));
    end

    // 2: C_TRANSPOSE base 0x3FC wraps, len ignored
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_base = 10'h3FC; cmd_len = 8'd0; cmd_l_k_0 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      cmd_valid = 1'b0;
      chk($sformatf("t2 enb c%0d", c), enb1, (c >= 1 && c <= 8));
      chk($sformatf("t2 addr c%0d", c), addr1, (c >= 1 && c <= 8) ? ((32'h3FC + c - 1) & 32'h3FF) : 0);
      chk($sformatf("t2 sel c%0d", c), sel1, (c >= 2 && c <= 9) ? 3'b110 : 3'b000);
      chk($sformatf("t2 seq c%0d", c), seq1, (c >= 2 && c <= 9) ? c - 2 : 0);
      chk($sformatf("t2 mov c%0d", c), mov1, (c >= 3 && c <= 10));
      chk($sformatf("t2 done c%0d", c), done1, (c == 11));
    end

    // 3: C_INV on the RD_LAT=2 instance
    cmd_valid2 = 1'b1; cmd_op = 3'b101; cmd_base = 10'h020; cmd_len = 8'd0; cmd_l_k_0 = 1'b1;
    nmov = 0; ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      cmd_valid2 = 1'b0;
      nmov += mov2; ndone += done2;
      chk($sformatf("t3 enb c%0d", c), enb2, (c >= 1 && c <= 8));
      chk($sformatf("t3 addr c%0d", c), addr2, (c >= 1 && c <= 8) ? 32'h020 + c - 1 : 0);
      chk($sformatf("t3 sel c%0d", c), sel2, (c >= 3 && c <= 10) ? 3'b111 : 3'b000);
      chk($sformatf("t3 lk c%0d", c), lk2, (c >= 3 && c <= 10));
      chk($sformatf("t3 seq c%0d", c), seq2, (c >= 3 && c <= 10) ? c - 3 : 0);
      chk($sformatf("t3 mov c%0d", c), mov2, (c >= 4 && c <= 11));
      chk($sformatf("t3 done c%0d", c), done2, (c == 12));
    end
    chk("t3 mov count", nmov, 8);
    chk("t3 done count", ndone, 1);

    // 4: illegal op 110
    cmd_valid = 1'b1; cmd_op = 3'b110; cmd_base = 10'h040; cmd_len = 8'd2;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      cmd_valid = 1'b0;
      chk($sformatf("t4 err c%0d", c), err1, (c == 1));
      chk($sformatf("t4 enb c%0d", c), enb1, 0);
      chk($sformatf("t4 rdy c%0d", c), rdy1, 1);
      chk($sformatf("t4 sel c%0d", c), sel1, 0);
    end

    // 5: B_NEG len 7 aborted by reset at step 4, then B_POS len 0
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_base = 10'h100; cmd_len = 8'd7; cmd_l_k_0 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      cmd_valid = 1'b0;
      chk($sformatf("t5 addr c%0d", c), addr1, 32'h100 + c - 1);
    end
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk_idle1("t5 abort");
    nmov = 0; ndone = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      nmov += mov1; ndone += done1;
    end
    chk("t5 no mov after abort", nmov, 0);
    chk("t5 no done after abort", ndone, 0);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_base = 10'h055; cmd_len = 8'd0; cmd_l_k_0 = 1'b0;
    nmov = 0; ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      cmd_valid = 1'b0;
      nmov += mov1; ndone += done1;
      if (c == 1) chk("t5 fresh addr", addr1, 10'h055);
      if (c == 2) chk("t5 fresh sel", sel1, 3'b001);
      if (c == 3) chk("t5 fresh mov", mov1, 1);
      if (c == 4) chk("t5 fresh done", done1, 1);
    end
    chk("t5 fresh mov count", nmov, 1);
    chk("t5 fresh done count", ndone, 1);

    // 6: back-to-back B_NEW len 1 with cmd_valid held
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_base = 10'h200; cmd_len = 8'd1; cmd_l_k_0 = 1'b0;
    hs_cyc = -1; done_cyc = -1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (done1 && done_cyc < 0) done_cyc = c;
      if (rdy1 && cmd_valid && hs_cyc < 0) hs_cyc = c;
      if (c == 7) begin
        cmd_valid = 1'b0;
        chk("t6 second enb", enb1, 1);
        chk("t6 second addr", addr1, 10'h200);
      end
      if (c == 3) chk("t6 first sel", sel1, 3'b011);
      if (c == 11) chk("t6 second done", done1, 1);
    end
    chk("t6 first done cycle", done_cyc, 5);
    chk("t6 second handshake cycle", hs_cyc, 6);
    chk("t6 end rdy", rdy1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
